// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if
// Receive-side handshake bundle of the UART receiver.
//   data_out   : received payload, LSB first on the line
//   data_valid : data_out / parity_err / frame_err hold a frame
//   data_ready : consumer accepts; a transfer happens when valid and ready are both high
//   parity_err : parity mismatch for the held frame
//   frame_err  : a stop bit of the held frame sampled low
//   overrun    : one-cycle pulse when a completed frame is dropped
// Modports: master = receiver side, slave = consumer side.
`timescale 1ns/1ps
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data_out, data_valid, parity_err, frame_err, overrun,
    input  data_ready
  );

  modport slave (
    input  data_out, data_valid, parity_err, frame_err, overrun,
    output data_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param
// Parameterised UART receiver with 2-of-3 majority sampling, optional
// parity, 1 or 2 stop bits, break handling and a valid/ready output stage
// that drops (and flags) a new frame when the held one was not consumed.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   rx   : asynchronous serial line, idle high
//   busy : receiver FSM not in IDLE
//   bus  : uart_rx_param_if.master (data_out, data_valid, data_ready,
//          parity_err, frame_err, overrun)
`timescale 1ns/1ps
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,   // 0 none, 1 odd, 2 even
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  output logic            busy,
  uart_rx_param_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_S2   = CW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK
  } state_t;

  state_t state, state_next;

  // Line synchroniser and edge detection
  logic       rx_meta, rx_sync, rx_prev;
  logic [1:0] prime;

  // Datapath
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 samp0, samp1;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 stop_err;

  // FSM control
  logic fall, at_last, at_vote, vote, counting;
  logic frame_start, cnt_clr, bit_inc, bit_clr;
  logic shift_en, par_en, stop_chk, complete;
  logic frame_perr, frame_ferr;

  // prime marks when rx_sync holds a real line sample rather than its reset
  // value; rx_prev only reports "high" for real samples, so a line that was
  // already low when reset released never looks like a fresh falling edge.
  always_ff @(posedge clk) begin
    // NOTE: clocked state always uses non-blocking assignments so every
    // flop samples the pre-edge values of the others.
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b0;
      prime   <= 2'b00;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      prime   <= {prime[0], 1'b1};
      rx_prev <= rx_sync & prime[1];
    end
  end

  assign fall     = rx_prev & ~rx_sync;
  assign at_last  = (clk_cnt == CNT_LAST);
  assign at_vote  = (clk_cnt == CNT_S2);
  // Third sample is the live synchronised value at count /2+1.
  assign vote     = (samp0 & samp1) | (samp0 & rx_sync) | (samp1 & rx_sync);
  assign counting = (state == S_START) || (state == S_DATA) ||
                    (state == S_PAR)   || (state == S_STOP);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_next  = state;
    frame_start = 1'b0;
    cnt_clr     = 1'b0;
    bit_inc     = 1'b0;
    bit_clr     = 1'b0;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    stop_chk    = 1'b0;
    complete    = 1'b0;
    busy        = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (fall) begin
          frame_start = 1'b1;
          cnt_clr     = 1'b1;
          bit_clr     = 1'b1;
          state_next  = S_START;
        end
      end
      S_START: begin
        if (at_vote && vote) begin
          cnt_clr    = 1'b1;       // false start: glitch, not a frame
          state_next = S_IDLE;
        end else if (at_last) begin
          cnt_clr    = 1'b1;
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        shift_en = at_vote;
        if (at_last) begin
          cnt_clr = 1'b1;
          if (bit_cnt == DATA_LAST) begin
            bit_clr    = 1'b1;
            state_next = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      S_PAR: begin
        par_en = at_vote;
        if (at_last) begin
          cnt_clr    = 1'b1;
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        stop_chk = at_vote;
        if (at_vote && (bit_cnt == STOP_LAST)) begin
          // The frame completes mid final stop bit, not at its end, so a
          // back-to-back start edge is never missed.
          complete   = 1'b1;
          cnt_clr    = 1'b1;
          state_next = vote ? S_IDLE : S_BREAK;
        end else if (at_last) begin
          cnt_clr = 1'b1;
          bit_inc = 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_sync) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      samp0    <= 1'b0;
      samp1    <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      if (cnt_clr || !counting) clk_cnt <= '0;
      else                      clk_cnt <= clk_cnt + CW'(1);

      if (bit_clr)      bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + BW'(1);

      if (clk_cnt == CNT_S0) samp0 <= rx_sync;
      if (clk_cnt == CNT_S1) samp1 <= rx_sync;

      // LSB arrives first, so shift in from the top.
      if (shift_en) shreg   <= {vote, shreg[DATA_BITS-1:1]};
      if (par_en)   par_bit <= vote;

      if (frame_start)           stop_err <= 1'b0;
      else if (stop_chk && !vote) stop_err <= 1'b1;
    end
  end

  // Error flags of the frame completing this cycle; the final stop bit is
  // still in flight in vote, not yet folded into stop_err.
  always_comb begin
    frame_ferr = stop_err | ~vote;
    case (PARITY)
      1:       frame_perr = ~(^{shreg, par_bit});
      2:       frame_perr = ^{shreg, par_bit};
      default: frame_perr = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.overrun <= 1'b0;
      if (complete && (!bus.data_valid || bus.data_ready)) begin
        bus.data_out   <= shreg;
        bus.parity_err <= frame_perr;
        bus.frame_err  <= frame_ferr;
        bus.data_valid <= 1'b1;
      end else if (complete) begin
        bus.overrun <= 1'b1;           // held frame wins, new one dropped
      end else if (bus.data_valid && bus.data_ready) begin
        bus.data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, meaning clk cycles per bit (1 MHz / 9600 baud); legal range 8..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame; legal values 1 or 2.
REQ-005 SHALL have port clk, input, 1, meaning single system clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-007 SHALL have port rx, input, 1, meaning asynchronous serial line, idle high.
REQ-008 SHALL have port data_out, output, DATA_BITS, meaning received payload, LSB first on line.
REQ-009 SHALL have port data_valid, output, 1, meaning data_out, parity_err and frame_err hold a frame.
REQ-010 SHALL have port data_ready, input, 1, meaning consumer accepts; transfer when data_valid and data_ready are both high.
REQ-011 SHALL have port parity_err, output, 1, meaning parity mismatch for the held frame; always 0 when PARITY=0.
REQ-012 SHALL have port frame_err, output, 1, meaning a stop bit sampled low for the held frame.
REQ-013 SHALL have port overrun, output, 1, meaning one-cycle pulse when a completed frame is dropped.
REQ-014 SHALL have port busy, output, 1, meaning FSM not in IDLE.

Function
REQ-015 SHALL pass rx through a 2-flop synchronizer, reset to 1; all decisions use the synchronized value.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PAR, STOP, BREAK.
REQ-017 IDLE -> START on a synchronized falling edge of rx; the bit counter clears to 0.
REQ-018 SHALL sample each bit by 2-of-3 majority vote of samples at counts CLKS_PER_BIT/2-1, /2, /2+1 (integer division).
REQ-019 START: a voted value of 1 is a false start -> IDLE with no output change; 0 -> DATA at the bit boundary (count CLKS_PER_BIT-1).
REQ-020 DATA: SHALL shift in DATA_BITS voted bits LSB first, then go to PAR if PARITY!=0, else STOP.
REQ-021 PAR: parity_err SHALL be set when the XOR of payload and parity bit is 0 for odd or 1 for even.
REQ-022 STOP: STOP_BITS bits are sampled; any low bit sets frame_err.
REQ-023 Frame completion SHALL occur at the voted sample of the final stop bit; outputs update on the next cycle, without waiting for the bit end.
REQ-024 After completion, the FSM SHALL go to IDLE if the final stop bit voted 1, else to BREAK; BREAK -> IDLE only once synchronized rx is 1.
REQ-025 On completion with data_valid=0, or data_valid=1 and data_ready=1 in the same cycle: load data_out/parity_err/frame_err and set data_valid=1; no overrun.
REQ-026 On completion with data_valid=1 and data_ready=0: keep held frame unchanged, discard new frame, pulse overrun for 1 cycle.
REQ-027 data_valid SHALL stay high with all held outputs stable until a transfer; it then clears the next cycle unless REQ-025 reloads.
REQ-028 Counters SHALL be sized clog2(CLKS_PER_BIT) and clog2(DATA_BITS+1); no wrap beyond the terminal count.

Reset
REQ-029 rst=1 SHALL force, next edge: state IDLE, counters 0, synchronizer 1, data_out 0, data_valid 0, parity_err 0, frame_err 0, overrun 0, busy 0.
REQ-030 rst SHALL take priority over all events, including a frame in progress; that partial frame is discarded and never presented.
REQ-031 After rst deasserts, a frame whose start edge arrived during reset SHALL NOT be received; reception requires a fresh falling edge.

Verification
REQ-032 Defaults, data_ready=1, send 8N1 0x31 at 104 clk/bit -> data_valid pulses once within 9.5 bit times + 4 clk of start edge, data_out=0x31, both errors 0.
REQ-033 rx low for 20 clk then high -> no data_valid, FSM returns to IDLE, busy low within 60 clk.
REQ-034 PARITY=2, send 0xA5 with parity bit 1 -> data_out=0xA5, parity_err=1; with parity bit 0 -> parity_err=0.
REQ-035 Send 0x55 with stop bit 0, rx held low 3 bit times -> frame_err=1, busy high until rx returns high, then next 0x0F received cleanly.
REQ-036 data_ready=0, send 0x11 then 0x22 back-to-back -> data_out stays 0x11, overrun pulses once, then data_ready=1 -> one transfer of 0x11 only.
REQ-037 Assert rst during bit 4 of 0x31, release, send 0x7E -> only 0x7E is presented, with no error flags.
